// File: rtl/digitallock_key_pio_if.sv
// Avalon-MM slave bus of the key PIO: register access and interrupt line.
interface digitallock_key_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/digitallock_key_pio.sv
// Debounced push-button PIO: per-key synchronizer and debounce counter,
// press edge capture with write-1-to-clear, maskable level interrupt.
module digitallock_key_pio #(
    parameter int WIDTH    = 4,
    parameter int DB_COUNT = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_port,
    digitallock_key_pio_if.slave bus
);

    localparam int CW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d_reg;
    logic [WIDTH-1:0] irqmask_reg;
    logic [WIDTH-1:0] edgecap_reg;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] wdata;
    logic             write_en;
    logic             unused_writedata;

    assign write_en = bus.chipselect & ~bus.write_n;
    assign wdata    = bus.writedata[WIDTH-1:0];
    // Upper write data bits have no destination.
    assign unused_writedata = ^bus.writedata;

    // Two-flop synchronizer; idles at released (1) so reset never looks like a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= in_port;
            sync2_reg <= sync1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
            logic [CW-1:0] cnt_reg;
            logic          stable_bit_reg;

            assign stable[gi] = stable_bit_reg;

            // Count consecutive mismatched cycles; adopt the new level once the run is long enough.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg        <= '0;
                    stable_bit_reg <= 1'b1;
                end else if (sync2_reg[gi] == stable_bit_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                    stable_bit_reg <= sync2_reg[gi];
                    cnt_reg        <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    // Delayed copy of the stable levels so a press is captured one edge after it settles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_d_reg <= '1;
        end else begin
            stable_d_reg <= stable;
        end
    end

    assign press = stable_d_reg & ~stable;

    // Interrupt mask register, written at address 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask_reg <= '0;
        end else if (write_en && bus.address == 2'd2) begin
            irqmask_reg <= wdata;
        end
    end

    // Edge capture: write-1-to-clear at address 3; a simultaneous press wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edgecap_reg <= '0;
        end else if (write_en && bus.address == 2'd3) begin
            edgecap_reg <= (edgecap_reg & ~wdata) | press;
        end else begin
            edgecap_reg <= edgecap_reg | press;
        end
    end

    // Zero-wait-state read mux, independent of chipselect.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata[WIDTH-1:0] = stable;
            2'd2:    bus.readdata[WIDTH-1:0] = irqmask_reg;
            2'd3:    bus.readdata[WIDTH-1:0] = edgecap_reg;
            default: bus.readdata = '0;
        endcase
    end

    assign bus.irq = |(edgecap_reg & irqmask_reg);

endmodule
